mem_port_arbiter: RTL and testbench

Shares the single 32-bit memory port of the multi-cycle MIPS core between the instruction-fetch unit and the load/store unit. It registers the winning request onto the port and drives the select of the 32-bit 2:1 address mux (0 = fetch address, 1 = data address). It holds the grant until the memory signals ready or a wait-state watchdog expires, then returns read data and a one-cycle completion pulse to the served requester.

---
 rtl/mem_port_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the shared MIPS memory port (instruction fetch vs. load/store).
// Define ARB_RR_EN for round-robin tie breaking; otherwise data has fixed priority.
module mem_port_arbiter #(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_done,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_done,
    output logic [31:0] d_rdata,
    output logic        err,
    output logic        addr_sel,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D, DONE} state_t;

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    state_t     state, state_nxt;
    logic [7:0] wait_cnt;
    logic       arb, busy, expire, finish;
    logic       req_if_v, req_d_v, prio_d, grant_d, grant_if;

`ifdef ARB_RR_EN
    logic last_d;

    // Tie goes to whichever requester was not granted most recently.
    assign prio_d = !last_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_d <= 1'b1;
        else if (grant_d)
            last_d <= 1'b1;
        else if (grant_if)
            last_d <= 1'b0;
    end
`else
    assign prio_d = 1'b1;
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        arb       = (state == IDLE) || (state == DONE);
        busy      = (state == BUSY_IF) || (state == BUSY_D);
        expire    = busy && !mem_ready && (wait_cnt == WAIT_LIMIT);
        finish    = busy && (mem_ready || expire);
        // addr_sel still names the requester that just completed while in DONE.
        req_if_v  = if_req && !((state == DONE) && !addr_sel);
        req_d_v   = d_req && !((state == DONE) && addr_sel);
        grant_d   = arb && req_d_v && (!req_if_v || prio_d);
        grant_if  = arb && req_if_v && !grant_d;
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (grant_d)
                    state_nxt = BUSY_D;
                else if (grant_if)
                    state_nxt = BUSY_IF;
                else
                    state_nxt = IDLE;
            end
            BUSY_IF, BUSY_D: begin
                if (finish)
                    state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_gnt    <= 1'b0;
            if_done   <= 1'b0;
            if_rdata  <= '0;
            d_gnt     <= 1'b0;
            d_done    <= 1'b0;
            d_rdata   <= '0;
            err       <= 1'b0;
            addr_sel  <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            wait_cnt  <= '0;
        end else begin
            if_done <= 1'b0;
            d_done  <= 1'b0;
            err     <= 1'b0;
            if (grant_d) begin
                d_gnt     <= 1'b1;
                if_gnt    <= 1'b0;
                addr_sel  <= 1'b1;
                mem_en    <= 1'b1;
                mem_we    <= d_we;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
                wait_cnt  <= '0;
            end else if (grant_if) begin
                if_gnt    <= 1'b1;
                d_gnt     <= 1'b0;
                addr_sel  <= 1'b0;
                mem_en    <= 1'b1;
                mem_we    <= 1'b0;
                mem_addr  <= if_addr;
                wait_cnt  <= '0;
            end
            if (finish) begin
                if_gnt <= 1'b0;
                d_gnt  <= 1'b0;
                mem_en <= 1'b0;
                mem_we <= 1'b0;
                err    <= !mem_ready;
                if (state == BUSY_D) begin
                    d_done <= 1'b1;
                    // Stores leave the load-data register untouched; a timeout clears it.
                    if (!mem_ready)
                        d_rdata <= '0;
                    else if (!mem_we)
                        d_rdata <= mem_rdata;
                end else begin
                    if_done  <= 1'b1;
                    if_rdata <= mem_ready ? mem_rdata : '0;
                end
            end else if (busy && (wait_cnt != 8'hFF)) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter, built with MAX_WAIT = 3.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, if_gnt, if_done;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_gnt, d_done;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        err, addr_sel, mem_en, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    mem_port_arbiter #(.MAX_WAIT(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
        .err(err), .addr_sel(addr_sel), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic first_d, win_d;
        logic [31:0] rd;
`ifdef ARB_RR_EN
        first_d = 1'b0;
`else
        first_d = 1'b1;
`endif
        rst_n = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
        step(); step();
        chk("rst_mem_en", mem_en, 0);
        chk("rst_gnt", {if_gnt, d_gnt}, 0);
        chk("rst_done_err", {if_done, d_done, err}, 0);
        chk("rst_addr_sel", addr_sel, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_rdata", if_rdata | d_rdata, 0);
        rst_n = 1'b1;
        step();

        // Single fetch, ready two cycles after mem_en.
        if_req = 1'b1; if_addr = 32'h0040_0000;
        step();
        chk("if_gnt", if_gnt, 1);
        chk("if_mem_en", mem_en, 1);
        chk("if_addr_sel", addr_sel, 0);
        chk("if_mem_we", mem_we, 0);
        chk("if_mem_addr", mem_addr, 32'h0040_0000);
        step();
        chk("if_wait_done", if_done, 0);
        step();
        mem_ready = 1'b1; mem_rdata = 32'h2402_0005;
        step();
        chk("if_done", if_done, 1);
        chk("if_rdata", if_rdata, 32'h2402_0005);
        chk("if_err", err, 0);
        chk("if_done_en", {if_gnt, mem_en}, 0);
        if_req = 1'b0; mem_ready = 1'b0;
        step();
        chk("if_done_pulse", if_done, 0);

        // Store: write data registered, load data untouched.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1001_0004; d_wdata = 32'hDEAD_BEEF;
        step();
        chk("st_gnt", d_gnt, 1);
        chk("st_mem_we", mem_we, 1);
        chk("st_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("st_addr", mem_addr, 32'h1001_0004);
        chk("st_addr_sel", addr_sel, 1);
        mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
        step();
        chk("st_done", d_done, 1);
        chk("st_rdata", d_rdata, 0);
        chk("st_if_rdata_held", if_rdata, 32'h2402_0005);
        d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
        step();

        // Simultaneous requests, ready immediately.
        if_req = 1'b1; if_addr = 32'h0040_0010;
        d_req = 1'b1; d_addr = 32'h1001_0020;
        mem_ready = 1'b1;
        for (int s = 0; s < 2; s++) begin
            win_d = (s == 0) ? first_d : !first_d;
            rd = (s == 0) ? 32'hAAAA_0001 : 32'hBBBB_0002;
            mem_rdata = rd;
            step();
            chk("tie_gnt", {d_gnt, if_gnt}, {30'd0, win_d, !win_d});
            chk("tie_addr_sel", addr_sel, win_d);
            chk("tie_mem_addr", mem_addr, win_d ? 32'h1001_0020 : 32'h0040_0010);
            step();
            chk("tie_done", {d_done, if_done}, {30'd0, win_d, !win_d});
            chk("tie_rdata", win_d ? d_rdata : if_rdata, rd);
            if (win_d) d_req = 1'b0;
            else       if_req = 1'b0;
        end
        mem_ready = 1'b0;
        step();

        // Timeout: ready never comes, done/err at N+5.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1001_0030;
        step();
        chk("to_gnt", d_gnt, 1);
        step(); step(); step();
        chk("to_early", d_done, 0);
        step();
        chk("to_done", d_done, 1);
        chk("to_err", err, 1);
        chk("to_rdata", d_rdata, 0);
        chk("to_mem_en", mem_en, 0);
        d_req = 1'b0;
        step();

        // Ready exactly at the limit wins over the timeout.
        d_req = 1'b1; d_addr = 32'h1001_0034;
        step(); step(); step(); step();
        mem_ready = 1'b1; mem_rdata = 32'hCAFE_0003;
        step();
        chk("lim_done", d_done, 1);
        chk("lim_err", err, 0);
        chk("lim_rdata", d_rdata, 32'hCAFE_0003);
        d_req = 1'b0; mem_ready = 1'b0;
        step();

        // Masking: fetch request held through its own done.
        if_req = 1'b1; if_addr = 32'h0040_0020; mem_ready = 1'b1; mem_rdata = 32'h1111_0004;
        step();
        chk("msk_gnt", if_gnt, 1);
        step();
        chk("msk_done", if_done, 1);
        step();
        chk("msk_no_regrant", {if_gnt, mem_en}, 0);
        step();
        chk("msk_regrant", {if_gnt, mem_en}, 3);
        step();
        chk("msk_done2", if_done, 1);
        if_req = 1'b0; mem_ready = 1'b0;
        step();

        // Reset during a data access.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1001_0040; d_wdata = 32'h55AA_55AA;
        step();
        chk("rb_gnt_we", {d_gnt, mem_we}, 3);
        step();
        rst_n = 1'b0;
        #2;
        chk("rb_gnt", {if_gnt, d_gnt}, 0);
        chk("rb_mem", {mem_en, mem_we, addr_sel}, 0);
        chk("rb_mem_addr", mem_addr, 0);
        chk("rb_wdata", mem_wdata, 0);
        chk("rb_rdata", if_rdata | d_rdata, 0);
        @(posedge clk); #1;
        d_req = 1'b0; d_we = 1'b0;
        rst_n = 1'b1;
        step();
        chk("rb_no_done", {d_done, err}, 0);
        step();
        chk("rb_no_done2", {d_done, d_gnt}, 0);

        d_req = 1'b1; d_addr = 32'h1001_0050; mem_ready = 1'b1; mem_rdata = 32'h7777_0005;
        step();
        chk("post_gnt", d_gnt, 1);
        chk("post_addr", mem_addr, 32'h1001_0050);
        chk("post_we", mem_we, 0);
        step();
        chk("post_done", d_done, 1);
        chk("post_rdata", d_rdata, 32'h7777_0005);
        d_req = 1'b0; mem_ready = 1'b0;
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
